// File: rtl/uartrx.sv
// uartrx: 16x-oversampled UART receiver (start, 8 data LSB first, parity, stop) with 2-of-3 bit voting.
// Define UARTRX_PARITY_EN to check the parity slot; otherwise the slot is timed but dataerror stays 0.
module uartrx #(
   parameter logic paritymode = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] dataout,
   output logic       rdsig,
   output logic       dataerror,
   output logic       frameerror,
   output logic       busy
);

   localparam int unsigned CntW  = 8;
   localparam int unsigned DataW = 8;
   localparam int unsigned IdxW  = 4;

   typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_RECV} state_e;

   state_e            state_q, state_d;
   logic              rx_s1_q, rx_s1_d;
   logic              rx_s2_q, rx_s2_d;
   logic              rx_s3_q, rx_s3_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        vote_q, vote_d;
   logic [DataW-1:0]  shadow_q, shadow_d;
   logic [DataW-1:0]  dataout_q, dataout_d;
   logic              rdsig_q, rdsig_d;
   logic              dataerror_q, dataerror_d;
   logic              frameerror_q, frameerror_d;
   logic              busy_q, busy_d;

   logic [CntW-1:0]   cnt_inc_c;
   logic [IdxW-1:0]   bit_idx_c;
   logic [IdxW-1:0]   phase_c;
   logic              maj_c;

`ifdef UARTRX_PARITY_EN
   logic              par_q, par_d;
`else
   logic              unused_paritymode_c;
   assign unused_paritymode_c = paritymode;
`endif

   // Events fire on the edge that moves cnt to the named value, so decode the incremented count.
   assign cnt_inc_c = cnt_q + CntW'(1);
   assign bit_idx_c = cnt_inc_c[CntW-1:IdxW];
   assign phase_c   = cnt_inc_c[IdxW-1:0];
   assign maj_c     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s2_q) | (vote_q[1] & rx_s2_q);

   always_comb begin
      state_d      = state_q;
      rx_s1_d      = rx;
      rx_s2_d      = rx_s1_q;
      rx_s3_d      = rx_s2_q;
      cnt_d        = cnt_q;
      vote_d       = vote_q;
      shadow_d     = shadow_q;
      dataout_d    = dataout_q;
      rdsig_d      = 1'b0;
      dataerror_d  = dataerror_q;
      frameerror_d = frameerror_q;
      busy_d       = busy_q;
`ifdef UARTRX_PARITY_EN
      par_d        = par_q;
`endif

      unique case (state_q)
         ST_ARM: begin
            if (rx_s2_q) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (!rx_s2_q && rx_s3_q) begin
               state_d = ST_RECV;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_RECV: begin
            cnt_d = cnt_inc_c;
            if (phase_c == IdxW'(7)) vote_d[0] = rx_s2_q;
            if (phase_c == IdxW'(8)) vote_d[1] = rx_s2_q;
            if (phase_c == IdxW'(9)) begin
               if (bit_idx_c == IdxW'(0)) begin
                  // A start bit that votes high was a glitch: drop back without touching outputs.
                  if (maj_c) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                  end
               end else if (bit_idx_c <= IdxW'(8)) begin
                  shadow_d = {maj_c, shadow_q[DataW-1:1]};
               end else if (bit_idx_c == IdxW'(9)) begin
`ifdef UARTRX_PARITY_EN
                  par_d = maj_c;
`endif
               end else begin
                  dataout_d    = shadow_q;
                  frameerror_d = ~maj_c;
                  rdsig_d      = 1'b1;
                  busy_d       = 1'b0;
                  state_d      = maj_c ? ST_IDLE : ST_ARM;
`ifdef UARTRX_PARITY_EN
                  dataerror_d  = ((^shadow_q) ^ paritymode) != par_q;
`else
                  dataerror_d  = 1'b0;
`endif
               end
            end
         end
         default: state_d = ST_ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ARM;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_s3_q      <= 1'b1;
         cnt_q        <= '0;
         vote_q       <= '0;
         shadow_q     <= '0;
         dataout_q    <= '0;
         rdsig_q      <= 1'b0;
         dataerror_q  <= 1'b0;
         frameerror_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef UARTRX_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rx_s1_q      <= rx_s1_d;
         rx_s2_q      <= rx_s2_d;
         rx_s3_q      <= rx_s3_d;
         cnt_q        <= cnt_d;
         vote_q       <= vote_d;
         shadow_q     <= shadow_d;
         dataout_q    <= dataout_d;
         rdsig_q      <= rdsig_d;
         dataerror_q  <= dataerror_d;
         frameerror_q <= frameerror_d;
         busy_q       <= busy_d;
`ifdef UARTRX_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   assign dataout    = dataout_q;
   assign rdsig      = rdsig_q;
   assign dataerror  = dataerror_q;
   assign frameerror = frameerror_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uartrx.sv
// tb_uartrx: directed frames from a 16-clk-per-bit transmitter model; rdsig events are logged and checked.
module tb_uartrx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] dataout;
   logic       rdsig;
   logic       dataerror;
   logic       frameerror;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc;
   logic mid_busy;

`ifdef UARTRX_PARITY_EN
   localparam logic PAR_ERR_EXP = 1'b1;
`else
   localparam logic PAR_ERR_EXP = 1'b0;
`endif

   typedef struct {
      int         c;
      logic [7:0] d;
      logic       de;
      logic       fe;
   } ev_t;
   ev_t evq[$];

   uartrx #(.paritymode(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .dataout   (dataout),
      .rdsig     (rdsig),
      .dataerror (dataerror),
      .frameerror(frameerror),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rdsig === 1'b1) evq.push_back('{cyc, dataout, dataerror, frameerror});
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Transmitter model: each bit held for 16 clocks; optional inverted sample at 16k+8; optional early stop.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input bit spike, input int abort_at);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      start_cyc = cyc;
      for (int k = 0; k < 11; k++) begin
         for (int j = 0; j < 16; j++) begin
            if (k * 16 + j == abort_at) return;
            rx = (spike && j == 8) ? ~bits[k] : bits[k];
            if (k == 5 && j == 0) mid_busy = busy;
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (dataout !== 8'h00) begin bad++; $display("FAIL reset_dataout: got %02h want 00", dataout); end
      total++; if (rdsig !== 1'b0) begin bad++; $display("FAIL reset_rdsig: got %b want 0", rdsig); end
      total++; if (dataerror !== 1'b0) begin bad++; $display("FAIL reset_dataerror: got %b want 0", dataerror); end
      total++; if (frameerror !== 1'b0) begin bad++; $display("FAIL reset_frameerror: got %b want 0", frameerror); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      idle(4);
   endtask

   task automatic test_basic();
      ev_t ev;
      int  t;
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1);
      t = start_cyc;
      total++; if (mid_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid: got %b want 1", mid_busy); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
      total++;
      if (evq.size() != 1) begin
         bad++; $display("FAIL basic_count: got %0d want 1", evq.size());
         evq.delete();
      end else begin
         ev = evq.pop_front();
         total++; if (ev.c !== t + 172) begin bad++; $display("FAIL basic_latency: got %0d want %0d", ev.c, t + 172); end
         total++; if (ev.d !== 8'h55) begin bad++; $display("FAIL basic_data: got %02h want 55", ev.d); end
         total++; if (ev.de !== 1'b0) begin bad++; $display("FAIL basic_dataerror: got %b want 0", ev.de); end
         total++; if (ev.fe !== 1'b0) begin bad++; $display("FAIL basic_frameerror: got %b want 0", ev.fe); end
      end
      idle(2);
   endtask

   task automatic test_parity();
      ev_t ev;
      send_frame(8'hA3, 1'b1, 1'b1, 1'b0, -1);
      idle(2);
      total++;
      if (evq.size() != 1) begin
         bad++; $display("FAIL parity_count: got %0d want 1", evq.size());
         evq.delete();
      end else begin
         ev = evq.pop_front();
         total++; if (ev.d !== 8'hA3) begin bad++; $display("FAIL parity_data: got %02h want a3", ev.d); end
         total++; if (ev.de !== PAR_ERR_EXP) begin bad++; $display("FAIL parity_dataerror: got %b want %b", ev.de, PAR_ERR_EXP); end
         total++; if (ev.fe !== 1'b0) begin bad++; $display("FAIL parity_frameerror: got %b want 0", ev.fe); end
      end
      total++; if (dataerror !== PAR_ERR_EXP) begin bad++; $display("FAIL parity_sticky: got %b want %b", dataerror, PAR_ERR_EXP); end
   endtask

   task automatic test_frame_error();
      ev_t ev;
      int  t;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      t = start_cyc;
      rx = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (evq.size() != 1) begin
         bad++; $display("FAIL ferr_count: got %0d want 1", evq.size());
         evq.delete();
      end else begin
         ev = evq.pop_front();
         total++; if (ev.c !== t + 172) begin bad++; $display("FAIL ferr_latency: got %0d want %0d", ev.c, t + 172); end
         total++; if (ev.d !== 8'h3C) begin bad++; $display("FAIL ferr_data: got %02h want 3c", ev.d); end
         total++; if (ev.fe !== 1'b1) begin bad++; $display("FAIL ferr_frameerror: got %b want 1", ev.fe); end
         total++; if (ev.de !== 1'b0) begin bad++; $display("FAIL ferr_dataerror: got %b want 0", ev.de); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_low: got %b want 0", busy); end
      idle(4);
      send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1);
      t = start_cyc;
      idle(2);
      total++;
      if (evq.size() != 1) begin
         bad++; $display("FAIL ferr_next_count: got %0d want 1", evq.size());
         evq.delete();
      end else begin
         ev = evq.pop_front();
         total++; if (ev.c !== t + 172) begin bad++; $display("FAIL ferr_next_latency: got %0d want %0d", ev.c, t + 172); end
         total++; if (ev.d !== 8'h81) begin bad++; $display("FAIL ferr_next_data: got %02h want 81", ev.d); end
         total++; if (ev.fe !== 1'b0) begin bad++; $display("FAIL ferr_next_frameerror: got %b want 0", ev.fe); end
         total++; if (ev.de !== 1'b0) begin bad++; $display("FAIL ferr_next_dataerror: got %b want 0", ev.de); end
      end
   endtask

   task automatic test_false_start();
      rx = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL fstart_busy_high: got %b want 1", busy); end
      idle(30);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL fstart_busy_low: got %b want 0", busy); end
      total++; if (evq.size() != 0) begin bad++; $display("FAIL fstart_rdsig: got %0d pulses want 0", evq.size()); evq.delete(); end
      total++; if (dataout !== 8'h81) begin bad++; $display("FAIL fstart_dataout: got %02h want 81", dataout); end
   endtask

   task automatic test_back_to_back(input bit spike);
      ev_t ev;
      int  t0, t1;
      send_frame(8'h12, 1'b0, 1'b1, spike, -1);
      t0 = start_cyc;
      idle(1);
      send_frame(8'hFE, 1'b1, 1'b1, spike, -1);
      t1 = start_cyc;
      idle(4);
      total++;
      if (evq.size() != 2) begin
         bad++; $display("FAIL b2b_count spike=%0d: got %0d want 2", spike, evq.size());
         evq.delete();
      end else begin
         ev = evq.pop_front();
         total++; if (ev.c !== t0 + 172) begin bad++; $display("FAIL b2b_lat0 spike=%0d: got %0d want %0d", spike, ev.c, t0 + 172); end
         total++; if (ev.d !== 8'h12) begin bad++; $display("FAIL b2b_data0 spike=%0d: got %02h want 12", spike, ev.d); end
         total++; if ({ev.de, ev.fe} !== 2'b00) begin bad++; $display("FAIL b2b_err0 spike=%0d: got %b%b want 00", spike, ev.de, ev.fe); end
         ev = evq.pop_front();
         total++; if (ev.c !== t1 + 172) begin bad++; $display("FAIL b2b_lat1 spike=%0d: got %0d want %0d", spike, ev.c, t1 + 172); end
         total++; if (ev.d !== 8'hFE) begin bad++; $display("FAIL b2b_data1 spike=%0d: got %02h want fe", spike, ev.d); end
         total++; if ({ev.de, ev.fe} !== 2'b00) begin bad++; $display("FAIL b2b_err1 spike=%0d: got %b%b want 00", spike, ev.de, ev.fe); end
      end
   endtask

   task automatic test_reset_mid();
      ev_t ev;
      int  t;
      // Abort once the receiver count has reached 80 (detect happens two clocks after the line falls).
      send_frame(8'h96, 1'b0, 1'b1, 1'b0, 83);
      rst_n = 1'b0;
      #1;
      total++; if (dataout !== 8'h00) begin bad++; $display("FAIL rmid_dataout: got %02h want 00", dataout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
      total++; if ({rdsig, dataerror, frameerror} !== 3'b000) begin bad++; $display("FAIL rmid_flags: got %b want 000", {rdsig, dataerror, frameerror}); end
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);
      total++; if (evq.size() != 0) begin bad++; $display("FAIL rmid_no_rdsig: got %0d want 0", evq.size()); evq.delete(); end
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1);
      t = start_cyc;
      idle(2);
      total++;
      if (evq.size() != 1) begin
         bad++; $display("FAIL rmid_next_count: got %0d want 1", evq.size());
         evq.delete();
      end else begin
         ev = evq.pop_front();
         total++; if (ev.c !== t + 172) begin bad++; $display("FAIL rmid_next_latency: got %0d want %0d", ev.c, t + 172); end
         total++; if (ev.d !== 8'h55) begin bad++; $display("FAIL rmid_next_data: got %02h want 55", ev.d); end
         total++; if ({ev.de, ev.fe} !== 2'b00) begin bad++; $display("FAIL rmid_next_err: got %b%b want 00", ev.de, ev.fe); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      test_reset();
      test_basic();
      test_parity();
      test_frame_error();
      test_false_start();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uartrx.md
Name: uartrx

Overview:
- UART receiver; the receive-side partner of the team's 16-clock-per-bit transmitter.
- Frame format: 1 start bit, 8 data bits (LSB first), 1 parity bit, 1 stop bit, 16 clk per bit.
- Synchronises the serial line, qualifies the start bit and majority-votes every bit.
- Presents each received byte with a one-cycle strobe plus parity and framing error flags to downstream logic (command parser / loopback into the transmitter).

Parameters:
paritymode, 1'b0, XOR seed for expected parity; 0 = even parity, 1 = odd; must match the transmitter setting.

Ports:
clk  input  1  UART clock, 16x bit rate
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
dataout  output  8  last received byte, held until the next frame completes
rdsig  output  1  one-clk strobe; dataout/dataerror/frameerror are valid in this cycle
dataerror  output  1  parity mismatch on the last frame
frameerror  output  1  stop bit sampled low on the last frame
busy  output  1  high from start-bit detection until the end of the frame

Behaviour:
- Reset (async, rst_n=0): dataout=0, rdsig=0, dataerror=0, frameerror=0, busy=0, state=ARM, cnt=0, sync flops=1.
- Input path: rx passes through 2 flops (rx_s1, rx_s2) and 1 history flop rx_s3. Falling edge = rx_s2==0 && rx_s3==1.
- States:
  - ARM: wait for rx_s2==1, then go to IDLE. A frame is never accepted until the line has been seen high after reset or a framing error.
  - IDLE: on a falling edge go to RECV; cnt<=0, busy<=1.
  - RECV: cnt increments by 1 every clk. Bit k (0 = start, 1..8 = data[0..7], 9 = parity, 10 = stop) starts at cnt = 16k. Its samples are taken at cnt = 16k+7, 16k+8, 16k+9. The bit value is the 2-of-3 majority, resolved on the cnt = 16k+9 edge.
  - Start check at cnt=9: if the majority is 1, it is a false start; go to IDLE, busy<=0, no rdsig, outputs unchanged.
  - Data bits shift in LSB first into a shadow register. dataout changes only at frame end.
  - Parity: calc = XOR(data[7:0]) ^ paritymode; dataerror_next = (calc != sampled parity bit).
  - Stop resolved at cnt=169: dataout<=shadow, dataerror<=dataerror_next, frameerror<=~stop, rdsig<=1 for exactly one clk, busy<=0.
  - Next state after stop: IDLE if stop==1; ARM if stop==0.
- Latency: rdsig is high in the cycle following the 171st clk edge after the edge that first samples rx low.
- A new start edge is accepted from the first cycle in IDLE, which supports back-to-back frames with a 1-clk-or-longer idle gap.
- Falling edges inside RECV are ignored. cnt never exceeds 169, so there is no wrap.
- Error flags are sticky until the next rdsig; they are then overwritten (not ORed).
- Reset mid-frame aborts immediately: all outputs go to reset values and no rdsig is issued.

Optional Feature:
UARTRX_PARITY_EN
- Defined: the parity slot is checked as above.
- Undefined: the parity slot is still timed and sampled (frame length unchanged), but dataerror is held constantly 0 and the parity logic is not synthesised.

Test Plan:
- Reset, rx=1, send 0x55 with parity 0 and stop 1 -> dataout=0x55, rdsig one pulse at the specified cycle, dataerror=0, frameerror=0, busy 1->0.
- Send 0xA3 with parity bit 1 (wrong for even; 0xA3 has 4 ones) -> dataout=0xA3, dataerror=1 if UARTRX_PARITY_EN is defined, else 0; frameerror=0.
- Send 0x3C with stop bit 0, then hold rx low 40 clk, then high, then send 0x81 -> first rdsig with frameerror=1; no frame while low; second frame dataout=0x81 with both error flags 0.
- rx low pulse of 5 clk from idle -> busy pulses high, no rdsig, dataout unchanged.
- Drive rx from the transmitter model with back-to-back 0x12, 0xFE -> two rdsig pulses with dataout 0x12 then 0xFE and no errors. Repeat with a 1-clk spike injected at each sample point 16k+8 -> same result (majority vote).
- Assert rst_n=0 at cnt=80 of a frame -> outputs go to 0 immediately. After release with rx=1, the next 0x55 frame is received correctly.
